// File: rtl/game_sequencer_if.sv
// Bundle between the match sequencer and the game datapaths.
// The master side (keyboard, video timing, ball logic) drives the
// inputs. The slave side (the sequencer) drives the control and
// score outputs.
interface game_sequencer_if;
    logic       frame_tick;
    logic [7:0] keycode;
    logic       miss_p1;
    logic       miss_p2;
    logic [2:0] game_state;
    logic       ball_reset;
    logic       ball_enable;
    logic       serve_dir;
    logic [3:0] score_p1;
    logic [3:0] score_p2;
    logic [1:0] speed_lvl;
    logic [1:0] winner;

    modport master (
        output frame_tick, keycode, miss_p1, miss_p2,
        input  game_state, ball_reset, ball_enable, serve_dir,
               score_p1, score_p2, speed_lvl, winner
    );

    modport slave (
        input  frame_tick, keycode, miss_p1, miss_p2,
        output game_state, ball_reset, ball_enable, serve_dir,
               score_p1, score_p2, speed_lvl, winner
    );
endinterface

// File: rtl/game_sequencer.sv
// Match sequencer for 3D Pong: attract, serve countdown, rally, pause
// and game-over hold, with per-player scoring and speed levels.
// Every output comes straight from a register.
module game_sequencer #(
    parameter int unsigned WIN_SCORE    = 7,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned OVER_FRAMES  = 120,
    parameter logic [7:0]  START_KEY    = 8'h2C,
    parameter logic [7:0]  PAUSE_KEY    = 8'h13
) (
    input  logic               Clk,
    input  logic               Reset,
    game_sequencer_if.slave    bus
);

    typedef enum logic [2:0] {
        ST_ATTRACT = 3'd0,
        ST_SERVE   = 3'd1,
        ST_PLAY    = 3'd2,
        ST_PAUSE   = 3'd3,
        ST_OVER    = 3'd4
    } state_t;

    localparam logic [3:0] WIN_L   = 4'(WIN_SCORE);
    localparam logic [7:0] SERVE_L = 8'(SERVE_FRAMES);
    localparam logic [7:0] OVER_L  = 8'(OVER_FRAMES);

    state_t     state_reg;
    logic [7:0] keycode_q_reg;
    logic [7:0] frame_cnt_reg;
    logic       ball_reset_reg;
    logic       ball_enable_reg;
    logic       serve_dir_reg;
    logic [3:0] score_p1_reg;
    logic [3:0] score_p2_reg;
    logic [1:0] speed_lvl_reg;
    logic [1:0] winner_reg;

    logic       start_press;
    logic       pause_press;
    logic [3:0] score_p1_next;
    logic [3:0] score_p2_next;

    // Rising-edge key detection: a held key yields a single press.
    assign start_press = (bus.keycode == START_KEY) && (keycode_q_reg != START_KEY);
    assign pause_press = (bus.keycode == PAUSE_KEY) && (keycode_q_reg != PAUSE_KEY);

    // WIN_SCORE <= 15 stops a score from ever reaching the wrap point.
    assign score_p1_next = score_p1_reg + 4'd1;
    assign score_p2_next = score_p2_reg + 4'd1;

    // Speed level is min(3, total >> 2), taken from a 5-bit total.
    function automatic logic [1:0] speed_of(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] total;
        total = {1'b0, a} + {1'b0, b};
        return total[4] ? 2'd3 : total[3:2];
    endfunction

    // Match state machine with registered outputs and score bookkeeping.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg       <= ST_ATTRACT;
            keycode_q_reg   <= 8'd0;
            frame_cnt_reg   <= 8'd0;
            ball_reset_reg  <= 1'b1;
            ball_enable_reg <= 1'b0;
            serve_dir_reg   <= 1'b0;
            score_p1_reg    <= 4'd0;
            score_p2_reg    <= 4'd0;
            speed_lvl_reg   <= 2'd0;
            winner_reg      <= 2'd0;
        end else begin
            keycode_q_reg <= bus.keycode;
            case (state_reg)
                ST_ATTRACT: begin
                    if (start_press) begin
                        state_reg     <= ST_SERVE;
                        frame_cnt_reg <= SERVE_L;
                        serve_dir_reg <= 1'b0;
                        score_p1_reg  <= 4'd0;
                        score_p2_reg  <= 4'd0;
                        speed_lvl_reg <= 2'd0;
                        winner_reg    <= 2'd0;
                    end
                end
                ST_SERVE: begin
                    if (bus.frame_tick) begin
                        if (frame_cnt_reg == 8'd1) begin
                            state_reg       <= ST_PLAY;
                            ball_reset_reg  <= 1'b0;
                            ball_enable_reg <= 1'b1;
                        end else begin
                            frame_cnt_reg <= frame_cnt_reg - 8'd1;
                        end
                    end
                end
                ST_PLAY: begin
                    if (bus.miss_p1 && bus.miss_p2) begin
                        // Simultaneous misses: replay the point, nobody scores.
                        state_reg       <= ST_SERVE;
                        frame_cnt_reg   <= SERVE_L;
                        ball_reset_reg  <= 1'b1;
                        ball_enable_reg <= 1'b0;
                    end else if (bus.miss_p1) begin
                        score_p2_reg    <= score_p2_next;
                        serve_dir_reg   <= 1'b0;
                        speed_lvl_reg   <= speed_of(score_p1_reg, score_p2_next);
                        ball_reset_reg  <= 1'b1;
                        ball_enable_reg <= 1'b0;
                        if (score_p2_next == WIN_L) begin
                            state_reg     <= ST_OVER;
                            winner_reg    <= 2'd2;
                            frame_cnt_reg <= OVER_L;
                        end else begin
                            state_reg     <= ST_SERVE;
                            frame_cnt_reg <= SERVE_L;
                        end
                    end else if (bus.miss_p2) begin
                        score_p1_reg    <= score_p1_next;
                        serve_dir_reg   <= 1'b1;
                        speed_lvl_reg   <= speed_of(score_p1_next, score_p2_reg);
                        ball_reset_reg  <= 1'b1;
                        ball_enable_reg <= 1'b0;
                        if (score_p1_next == WIN_L) begin
                            state_reg     <= ST_OVER;
                            winner_reg    <= 2'd1;
                            frame_cnt_reg <= OVER_L;
                        end else begin
                            state_reg     <= ST_SERVE;
                            frame_cnt_reg <= SERVE_L;
                        end
                    end else if (pause_press) begin
                        state_reg       <= ST_PAUSE;
                        ball_enable_reg <= 1'b0;
                    end
                end
                ST_PAUSE: begin
                    // The ball stays where it is (no reset), motion is frozen.
                    if (pause_press) begin
                        state_reg       <= ST_PLAY;
                        ball_enable_reg <= 1'b1;
                    end
                end
                ST_OVER: begin
                    if (start_press && (frame_cnt_reg == 8'd0)) begin
                        state_reg     <= ST_SERVE;
                        frame_cnt_reg <= SERVE_L;
                        serve_dir_reg <= 1'b0;
                        score_p1_reg  <= 4'd0;
                        score_p2_reg  <= 4'd0;
                        speed_lvl_reg <= 2'd0;
                        winner_reg    <= 2'd0;
                    end else if (bus.frame_tick && (frame_cnt_reg != 8'd0)) begin
                        frame_cnt_reg <= frame_cnt_reg - 8'd1;
                    end
                end
                default: begin
                    state_reg       <= ST_ATTRACT;
                    ball_reset_reg  <= 1'b1;
                    ball_enable_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.game_state  = state_reg;
    assign bus.ball_reset  = ball_reset_reg;
    assign bus.ball_enable = ball_enable_reg;
    assign bus.serve_dir   = serve_dir_reg;
    assign bus.score_p1    = score_p1_reg;
    assign bus.score_p2    = score_p2_reg;
    assign bus.speed_lvl   = speed_lvl_reg;
    assign bus.winner      = winner_reg;

endmodule
